cs_cmd_sequencer: RTL and testbench

// - Upstream command sequencer for the computational storage array; sits between the host request

---
 rtl/cs_cmd_sequencer_if.sv | 35 +++
 rtl/cs_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_cs_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_cmd_sequencer_if.sv
// Host-side bus of the computational-storage command sequencer.
//   master : host side (drives req_*, receives req_ready, rsp_*, busy)
//   slave  : sequencer side
// Signals:
//   req_valid/req_ready  request handshake, push on valid&ready
//   req_cmd              00 RD, 01 WR, 10 ADD, 11 SUB
//   req_addA/B/C         source A, source B, destination
//   req_wdata            write data (WR only)
//   rsp_valid/rsp_data   one-cycle read-data pulse, no backpressure
//   busy                 queue non-empty or command in flight
interface cs_cmd_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [ADDR_W-1:0] req_addA;
  logic [ADDR_W-1:0] req_addB;
  logic [ADDR_W-1:0] req_addC;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output req_valid, req_cmd, req_addA, req_addB, req_addC, req_wdata,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_addA, req_addB, req_addC, req_wdata,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/cs_cmd_sequencer.sv
// cs_cmd_sequencer: upstream command sequencer for the computational storage
// array. Queues host ops in a small FIFO, issues at most one array command per
// cycle on registered cs_* pins, owns the cs_DQ tri-state and returns RD data
// on the host response channel.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   host (slave)      request / response / busy bus (cs_cmd_sequencer_if)
//   cs_cmd            array command, registered (00 RD is the idle value)
//   cs_addA/B/C       array addresses, registered (0 when idle)
//   cs_DQ             array data bus; driven with write data only during WR
// Build option:
//   CS_SEQ_READBACK_EN  after each ADD/SUB, spend one extra cycle reading back
//                       the destination and return it as a response.
module cs_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  cs_cmd_sequencer_if.slave host,
  output logic [1:0]        cs_cmd,
  output logic [ADDR_W-1:0] cs_addA,
  output logic [ADDR_W-1:0] cs_addB,
  output logic [ADDR_W-1:0] cs_addC,
  inout  wire  [DATA_W-1:0] cs_DQ
);
  localparam logic [1:0] CMD_RD = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    logic [DATA_W-1:0] wdata;
  } op_t;

`ifdef CS_SEQ_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RB} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;
`endif

  state_t                  state, state_nxt;
  op_t [FIFO_DEPTH-1:0]    fifo_q;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full, empty, push, pop, bypass, fifo_wr, goto_rb;
  op_t                     req_op, head_op, nxt_op;
  logic                    rd_live, rd_nxt;
  logic [DATA_W-1:0]       wdata_q;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign host.req_ready = !full && !reset;
  assign push    = host.req_valid && host.req_ready;
  assign req_op  = '{host.req_cmd, host.req_addA, host.req_addB,
                     host.req_addC, host.req_wdata};
  assign head_op = fifo_q[rd_ptr];
  // Bypass only into an empty queue, so order is kept; a full queue never
  // bypasses because it is by definition non-empty.
  assign fifo_wr = push && !bypass;

`ifdef CS_SEQ_READBACK_EN
  // An ADD/SUB on the pins forces one readback cycle before the next pop.
  assign goto_rb = (state == S_ISSUE) && cs_cmd[1];
`else
  assign goto_rb = 1'b0;
`endif

  // The state names what the cs_* registers present in the current cycle.
  always_comb begin
    state_nxt = S_IDLE;
    pop       = 1'b0;
    bypass    = 1'b0;
    nxt_op    = '0;
    rd_nxt    = 1'b0;
    if (goto_rb) begin
      nxt_op.cmd = CMD_RD;
      nxt_op.a   = cs_addC;
      rd_nxt     = 1'b1;
    end else if (!empty) begin
      pop    = 1'b1;
      nxt_op = head_op;
    end else if (push) begin
      bypass = 1'b1;
      nxt_op = req_op;
    end
    if (pop || bypass) rd_nxt = (nxt_op.cmd == CMD_RD);
    case (state)
      S_IDLE:  if (pop || bypass) state_nxt = S_ISSUE;
`ifdef CS_SEQ_READBACK_EN
      S_ISSUE: if (goto_rb) state_nxt = S_RB;
               else if (pop || bypass) state_nxt = S_ISSUE;
      S_RB:    if (pop || bypass) state_nxt = S_ISSUE;
`else
      S_ISSUE: if (pop || bypass) state_nxt = S_ISSUE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cs_cmd         <= CMD_RD;
      cs_addA        <= '0;
      cs_addB        <= '0;
      cs_addC        <= '0;
      wdata_q        <= '0;
      rd_live        <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
    end else begin
      state   <= state_nxt;
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      cs_cmd  <= nxt_op.cmd;
      cs_addA <= nxt_op.a;
      cs_addB <= nxt_op.b;
      cs_addC <= nxt_op.c;
      wdata_q <= nxt_op.wdata;
      rd_live <= rd_nxt;
      // The array drives memory[addA] combinationally during a RD cycle;
      // capture it at the end of that cycle.
      host.rsp_valid <= rd_live;
      if (rd_live) host.rsp_data <= cs_DQ;
    end
  end

  // Storage has no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_q[wr_ptr] <= req_op;
  end

  assign cs_DQ     = (cs_cmd == CMD_WR) ? wdata_q : {DATA_W{1'bz}};
  assign host.busy = !empty || (state != S_IDLE) || rd_live;
endmodule

// File: tb/tb_cs_cmd_sequencer.sv
module tb_cs_cmd_sequencer;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ADD = 2'b10, SUB = 2'b11;
`ifdef CS_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct { logic [15:0] data; int due; } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cs_cmd;
  logic [7:0]  cs_addA, cs_addB, cs_addC;
  wire  [15:0] cs_dq;
  logic        arr_oe = 1'b0;
  logic [15:0] amem [256];
  logic [15:0] ref_mem [256];
  exp_t        sbq [$];
  int          checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  cs_cmd_sequencer_if #(.ADDR_W(8), .DATA_W(16)) host ();

  cs_cmd_sequencer #(.FIFO_DEPTH(4), .ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .host(host), .cs_cmd(cs_cmd),
    .cs_addA(cs_addA), .cs_addB(cs_addB), .cs_addC(cs_addC), .cs_DQ(cs_dq)
  );

  // Undriven bus reads all-ones, so a released bus is distinguishable.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (cs_dq[i]);
  end

  // Array model: drives memory[addA] during RD, commits writes at the edge.
  assign cs_dq = (arr_oe && cs_cmd == RD) ? amem[cs_addA] : 16'hzzzz;
  always @(posedge clk) begin
    case (cs_cmd)
      WR:      amem[cs_addC] <= cs_dq;
      ADD:     amem[cs_addC] <= amem[cs_addA] + amem[cs_addB];
      SUB:     amem[cs_addC] <= amem[cs_addA] - amem[cs_addB];
      default: ;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // One cycle: sample at the falling edge and check any response.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (host.rsp_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got data %h, required no response", host.rsp_data);
      end else begin
        e = sbq.pop_front();
        if (host.rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp_data: got %h, required %h", host.rsp_data, e.data);
        end
        if (e.due >= 0) begin
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL rsp_latency: got cycle %0d, required %0d", cyc, e.due);
          end
        end
      end
    end
  endtask

  // Reference model applied in program order when an op is accepted.
  task automatic model(input logic [1:0] cmd, input logic [7:0] a, b, c,
                       input logic [15:0] d, input bit lat);
    exp_t e;
    case (cmd)
      RD: begin
        e.data = ref_mem[a]; e.due = lat ? cyc + 2 : -1; sbq.push_back(e);
      end
      WR: ref_mem[c] = d;
      default: begin
        ref_mem[c] = (cmd == ADD) ? ref_mem[a] + ref_mem[b] : ref_mem[a] - ref_mem[b];
        if (RB) begin e.data = ref_mem[c]; e.due = -1; sbq.push_back(e); end
      end
    endcase
  endtask

  // Called just after a falling edge; returns in the cycle after acceptance
  // with req_valid still high.
  task automatic send(input logic [1:0] cmd, input logic [7:0] a, b, c,
                      input logic [15:0] d, input bit lat, output int waits);
    host.req_valid = 1'b1; host.req_cmd = cmd;
    host.req_addA = a; host.req_addB = b; host.req_addC = c; host.req_wdata = d;
    waits = 0;
    while (host.req_ready !== 1'b1 && waits < 40) begin tick(); waits++; end
    if (waits >= 40) begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready stuck %b, required 1", host.req_ready);
      host.req_valid = 1'b0;
      return;
    end
    model(cmd, a, b, c, d, lat);
    tick();
  endtask

  task automatic drop();
    host.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 60) begin tick(); n++; end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    drop();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (host.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", host.req_ready);
    end
    repeat (5) tick();
    checks += 6;
    if (cs_cmd !== RD) begin errors++; $display("FAIL idle_cmd: got %b, required 00", cs_cmd); end
    if ({cs_addA, cs_addB, cs_addC} !== 24'h0) begin
      errors++; $display("FAIL idle_addr: got %h %h %h, required 0", cs_addA, cs_addB, cs_addC);
    end
    if (cs_dq !== 16'hFFFF) begin errors++; $display("FAIL idle_dq: got %h, required released (ffff)", cs_dq); end
    if (host.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", host.busy); end
    if (host.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, required 1", host.req_ready); end
    if ({host.rsp_valid, host.rsp_data} !== 17'h0) begin
      errors++; $display("FAIL idle_rsp: got %b/%h, required 0/0000", host.rsp_valid, host.rsp_data);
    end
  endtask

  task automatic test_wr_rd();
    int w;
    arr_oe = 1'b1;
    send(WR, 8'h00, 8'h00, 8'h10, 16'h1234, 1'b0, w);
    drop();
    checks += 3;
    if (cs_cmd !== WR || cs_addC !== 8'h10) begin
      errors++; $display("FAIL wr_issue: got cmd %b addC %h, required 01 10", cs_cmd, cs_addC);
    end
    if (cs_dq !== 16'h1234) begin errors++; $display("FAIL wr_dq: got %h, required 1234", cs_dq); end
    if (host.busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, required 1", host.busy); end
    tick();
    send(RD, 8'h10, 8'h00, 8'h00, 16'h0, 1'b1, w);
    drop();
    checks++;
    if (cs_cmd !== RD || cs_addA !== 8'h10) begin
      errors++; $display("FAIL rd_issue: got cmd %b addA %h, required 00 10", cs_cmd, cs_addA);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [15:0] d;
    for (int i = 0; i < 6; i++) begin
      d = 16'hA000 + 16'(i * 'h111);
      send(WR, 8'h00, 8'h00, 8'(8'h20 + i), d, 1'b0, w);
      checks += 2;
      if (w != 0) begin errors++; $display("FAIL b2b_ready: op %0d waited %0d cycles, required 0", i, w); end
      if (cs_cmd !== WR || cs_addC !== 8'(8'h20 + i) || cs_dq !== d) begin
        errors++;
        $display("FAIL b2b_issue: op %0d got %b %h %h, required 01 %h %h", i, cs_cmd, cs_addC, cs_dq, 8'(8'h20 + i), d);
      end
    end
    for (int i = 0; i < 6; i++) send(RD, 8'(8'h20 + i), 8'h00, 8'h00, 16'h0, 1'b1, w);
    drop();
    drain();
  endtask

  task automatic test_wrap();
    int w;
    send(WR, 8'h00, 8'h00, 8'h01, 16'hFFFF, 1'b0, w);
    send(WR, 8'h00, 8'h00, 8'h02, 16'h0002, 1'b0, w);
    send(ADD, 8'h01, 8'h02, 8'h03, 16'h0, 1'b0, w);
    send(RD, 8'h03, 8'h00, 8'h00, 16'h0, !RB, w);
    drop();
    drain();
  endtask

  task automatic test_sub();
    int w;
    send(WR, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, w);
    send(WR, 8'h00, 8'h00, 8'h01, 16'h0001, 1'b0, w);
    send(SUB, 8'h00, 8'h01, 8'h04, 16'h0, 1'b0, w);
    send(RD, 8'h04, 8'h00, 8'h00, 16'h0, !RB, w);
    drop();
    drain();
  endtask

  // Continuous SUB stream; queue occupancy = accepted - issued.
  task automatic test_fill();
    int acc = 0, iss = 0, stalls = 0;
    bit exp_rdy;
    for (int t = 0; t < 200 && iss < 10; t++) begin
      if (acc < 10) begin
        host.req_valid = 1'b1; host.req_cmd = SUB;
        host.req_addA = 8'(8'h20 + (acc % 6)); host.req_addB = 8'h02;
        host.req_addC = 8'(8'h50 + acc); host.req_wdata = 16'h0;
      end else drop();
      if (cs_cmd === SUB) begin
        checks++;
        if (cs_addC !== 8'(8'h50 + iss)) begin
          errors++; $display("FAIL fill_order: got addC %h, required %h", cs_addC, 8'(8'h50 + iss));
        end
        iss++;
      end
      if (host.req_valid) begin
        exp_rdy = ((acc - iss) != 4);
        checks++;
        if (host.req_ready !== exp_rdy) begin
          errors++; $display("FAIL fill_ready: got %b, required %b (queued %0d)", host.req_ready, exp_rdy, acc - iss);
        end
        if (host.req_ready === 1'b1) begin
          model(SUB, host.req_addA, host.req_addB, host.req_addC, 16'h0, 1'b0);
          acc++;
        end else stalls++;
      end
      tick();
    end
    drop();
    checks += 2;
    if (iss != 10) begin errors++; $display("FAIL fill_issue: got %0d issued, required 10", iss); end
    if ((stalls > 0) != RB) begin errors++; $display("FAIL fill_stall: got %0d stall cycles, required stalls=%b", stalls, RB); end
    drain();
  endtask

  task automatic test_reset_midop();
    int w;
    send(WR, 8'h00, 8'h00, 8'h05, 16'hAAAA, 1'b0, w);
    drop();
    drain();
    send(RD, 8'h10, 8'h00, 8'h00, 16'h0, 1'b1, w);
    host.req_cmd = WR; host.req_addC = 8'h05; host.req_wdata = 16'h5555;
    reset = 1'b1;
    sbq.delete();
    tick();
    checks += 2;
    if (cs_cmd !== RD) begin errors++; $display("FAIL rst_cmd: got %b, required 00", cs_cmd); end
    if (host.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b, required 0", host.rsp_valid); end
    reset = 1'b0;
    drop();
    arr_oe = 1'b0;
    tick();
    checks += 4;
    if (host.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", host.req_ready); end
    if (cs_dq !== 16'hFFFF) begin errors++; $display("FAIL rst_dq: got %h, required released (ffff)", cs_dq); end
    if (host.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", host.busy); end
    if (host.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp2: got %b, required 0", host.rsp_valid); end
    arr_oe = 1'b1;
    tick();
    checks++;
    if (amem[5] !== 16'hAAAA) begin errors++; $display("FAIL rst_nowrite: array[5] got %h, required aaaa", amem[5]); end
    send(RD, 8'h05, 8'h00, 8'h00, 16'h0, 1'b1, w);
    drop();
    drain();
  endtask

  initial begin
    host.req_valid = 1'b0; host.req_cmd = RD;
    host.req_addA = '0; host.req_addB = '0; host.req_addC = '0; host.req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    test_reset();
    test_wr_rd();
    test_back_to_back();
    test_wrap();
    test_sub();
    test_fill();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
